mod_mul: RTL and testbench



---
 rtl/mod_mul_pkg.sv | 17 +
 rtl/mod_mul_if.sv | 25 ++
 rtl/mod_mul_dbl_add.sv | 30 +++
 rtl/mod_mul.sv | 109 ++++++++++
 tb/tb_mod_mul.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mod_mul_pkg.sv
// Shared prime-field definitions for the modular multiplier and its companion divider.
// Holds the default operand width, the counter width, the FSM state encoding and the default curve modulus.
package mod_mul_pkg;

    localparam int FP_W  = 256;
    localparam int FP_CW = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [255:0] FP_P_DEFAULT =
        256'h8542D69E_4C044F18_E8B92435_BF6FF7DE_45728391_5C45517D_722EDB8B_08F1DFC3;

endpackage

// File: rtl/mod_mul_if.sv
// Request/response bundle of the modular multiplier.
// The master issues operands and start; the slave returns busy, done and result.
interface mod_mul_if #(
    parameter int W = mod_mul_pkg::FP_W
) ();

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    modport master (
        output start, a, b, p,
        input  busy, done, result
    );

    modport slave (
        input  start, a, b, p,
        output busy, done, result
    );

endinterface

// File: rtl/mod_mul_dbl_add.sv
// One MSB-first interleaved multiply step: acc_o = (2*acc_i + bit_i*b_i) mod p_i.
// The caller keeps acc_i < p_i; with b_i < p_i the sum stays below 3p, so W+2 bits never overflow.
module mod_mul_dbl_add #(
    parameter int W = mod_mul_pkg::FP_W
) (
    input  logic [W+1:0] acc_i,
    input  logic         bit_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] p_i,
    output logic [W+1:0] acc_o
);

    logic [W+1:0] p_ext;
    logic [W+1:0] b_ext;
    logic [W+1:0] t_dbl;
    logic [W+1:0] t_red;
    logic [W+1:0] t_add;

    assign p_ext = {2'b00, p_i};
    assign b_ext = {2'b00, b_i};

    // Double, reduce once, conditionally add b, then reduce again.
    always_comb begin
        t_dbl = acc_i << 1;
        t_red = (t_dbl >= p_ext) ? (t_dbl - p_ext) : t_dbl;
        t_add = bit_i ? (t_red + b_ext) : t_red;
        acc_o = (t_add >= p_ext) ? (t_add - p_ext) : t_add;
    end

endmodule

// File: rtl/mod_mul.sv
// Bit-serial interleaved modular multiplier: result = a*b mod p.
// Scans one multiplier bit per cycle, MSB first; W+2 cycles from accept to the done pulse.
module mod_mul
    import mod_mul_pkg::*;
#(
    parameter int W  = FP_W,
    parameter int CW = FP_CW
) (
    input logic      clk,
    input logic      rst_n,
    mod_mul_if.slave bus
);

    // Index width needed to select one bit of the W-bit multiplier.
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    state_e       state_q, state_d;
    logic [W-1:0] a_q, b_q, p_q;
    logic [W+1:0] acc_q, acc_d;
    logic [W+1:0] acc_step;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0] result_q, result_d;
    logic         done_q, done_d;
    logic         load;
    logic         a_bit;

    assign a_bit = a_q[cnt_q[IW-1:0]];

    mod_mul_dbl_add #(.W(W)) u_step (
        .acc_i (acc_q),
        .bit_i (a_bit),
        .b_i   (b_q),
        .p_i   (p_q),
        .acc_o (acc_step)
    );

    // busy stays high through the done cycle so it drops together with done.
    assign bus.busy   = (state_q != ST_IDLE) || done_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

    // Next-state and datapath control. While done_q is high the FSM is already
    // back in IDLE, but a start in that cycle must still be ignored.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        load     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !done_q) begin
                    load    = 1'b1;
                    acc_d   = '0;
                    cnt_d   = CW'(W - 1);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = acc_step;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                result_d = acc_q[W-1:0];
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, accumulator, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Operand capture on accept; the inputs are free to change afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            p_q <= '0;
        end else if (load) begin
            a_q <= bus.a;
            b_q <= bus.b;
            p_q <= bus.p;
        end
    end

endmodule

// File: tb/tb_mod_mul.sv
// Self-checking bench for mod_mul at W=256 with the default curve modulus.
module tb_mod_mul;
    import mod_mul_pkg::*;

    localparam int W  = 256;
    localparam int CW = 9;
    localparam logic [W-1:0] P = FP_P_DEFAULT;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    mod_mul_if #(.W(W)) bus ();

    mod_mul #(.W(W), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain big-integer product reduced modulo m.
    function automatic logic [W-1:0] mulmod(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [W-1:0] m);
        logic [2*W-1:0] prod;
        prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        prod = prod % {{W{1'b0}}, m};
        return prod[W-1:0];
    endfunction

    function automatic logic [W-1:0] powmod(input logic [W-1:0] base, input logic [W-1:0] e,
                                            input logic [W-1:0] m);
        logic [W-1:0] r;
        r = 1;
        for (int i = W - 1; i >= 0; i--) begin
            r = mulmod(r, r, m);
            if (e[i]) r = mulmod(r, base, m);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_fe();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v % P;
    endfunction

    // One full transaction: accept, latency to done, result, single-cycle done.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] exp);
        int cycles;
        @(negedge clk);
        bus.a = av;
        bus.b = bv;
        bus.p = P;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = rand_fe();
        bus.b = rand_fe();
        cycles = 1;
        check({tag, ".busy"}, W'(bus.busy), W'(1));
        while (!bus.done && cycles < W + 10) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, ".latency"}, W'(cycles), W'(W + 2));
        check({tag, ".result"}, bus.result, exp);
        @(posedge clk);
        #1;
        check({tag, ".done_width"}, W'(bus.done), W'(0));
        check({tag, ".busy_fall"}, W'(bus.busy), W'(0));
        $display("op %s: a=%h b=%h result=%h cycles=%0d", tag, av, bv, bus.result, cycles);
    endtask

    initial begin
        logic [W-1:0] ra, rb, rq, exp1;
        int rises[$];
        int highs;
        int donecnt;
        logic [W-1:0] res_seen[$];

        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.p = P;
        #1;
        check("reset.busy", W'(bus.busy), W'(0));
        check("reset.done", W'(bus.done), W'(0));
        check("reset.result", bus.result, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("small", W'(5), W'(9), W'(45));
        run_op("pm1_sq", P - 1, P - 1, W'(1));
        ra = rand_fe();
        run_op("a_zero", '0, ra, '0);
        run_op("a_one", W'(1), ra, ra);
        run_op("two_pm1", W'(2), P - 1, P - 2);

        for (int i = 0; i < 40; i++) begin
            ra = rand_fe();
            rb = rand_fe();
            run_op($sformatf("rand%0d", i), ra, rb, mulmod(ra, rb, P));
        end

        // Divider round-trip: q = b/a mod p via Fermat inverse, then q*a must give b.
        for (int i = 0; i < 3; i++) begin
            ra = rand_fe();
            if (ra == '0) ra = W'(3);
            rb = rand_fe();
            rq = mulmod(rb, powmod(ra, P - 2, P), P);
            run_op($sformatf("roundtrip%0d", i), rq, ra, rb);
        end

        // Start held high: one result per W+3 cycles, each done one cycle wide.
        ra = rand_fe();
        rb = rand_fe();
        exp1 = mulmod(ra, rb, P);
        @(negedge clk);
        bus.a = ra;
        bus.b = rb;
        bus.start = 1'b1;
        highs = 0;
        for (int i = 0; i < 3 * (W + 3); i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                highs++;
                if (rises.size() == 0 || rises[$] != i - 1) rises.push_back(i);
                res_seen.push_back(bus.result);
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("cont.pulses", W'(rises.size()), W'(3));
        check("cont.highs", W'(highs), W'(3));
        if (rises.size() >= 3) begin
            check("cont.first", W'(rises[0]), W'(W + 1));
            check("cont.period1", W'(rises[1] - rises[0]), W'(W + 3));
            check("cont.period2", W'(rises[2] - rises[1]), W'(W + 3));
        end
        foreach (res_seen[k]) check($sformatf("cont.result%0d", k), res_seen[k], exp1);
        $display("op cont: pulses=%0d highs=%0d", rises.size(), highs);
        for (int i = 0; i < 2 * W + 10 && bus.busy; i++) begin
            @(posedge clk);
            #1;
        end
        check("cont.idle", W'(bus.busy), W'(0));

        // Start pulse mid-CALC with different operands must be ignored.
        ra = rand_fe();
        rb = rand_fe();
        exp1 = mulmod(ra, rb, P);
        @(negedge clk);
        bus.a = ra;
        bus.b = rb;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        begin
            int cycles;
            cycles = 1;
            while (!bus.done && cycles < W + 10) begin
                if (cycles == 50) begin
                    @(negedge clk);
                    bus.a = rand_fe();
                    bus.b = rand_fe();
                    bus.start = 1'b1;
                    @(posedge clk);
                    #1;
                    bus.start = 1'b0;
                end else begin
                    @(posedge clk);
                    #1;
                end
                cycles++;
            end
            check("midstart.latency", W'(cycles), W'(W + 2));
            check("midstart.result", bus.result, exp1);
        end
        donecnt = 0;
        for (int i = 0; i < W + 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) donecnt++;
        end
        check("midstart.no_extra_done", W'(donecnt), W'(0));
        check("midstart.result_hold", bus.result, exp1);
        $display("op midstart: result=%h extra_done=%0d", bus.result, donecnt);

        // Asynchronous reset at iteration 100.
        @(negedge clk);
        bus.a = rand_fe();
        bus.b = rand_fe();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (100) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rstmid.busy", W'(bus.busy), W'(0));
        check("rstmid.done", W'(bus.done), W'(0));
        check("rstmid.result", bus.result, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        donecnt = 0;
        for (int i = 0; i < W + 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) donecnt++;
        end
        check("rstmid.no_done", W'(donecnt), W'(0));
        $display("op rstmid: done_after_reset=%0d", donecnt);
        ra = rand_fe();
        rb = rand_fe();
        run_op("after_reset", ra, rb, mulmod(ra, rb, P));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
